// File: rtl/frame_scrambler.sv
// rtl/frame_scrambler.sv - per-frame seeded byte scrambler with a single registered output stage
// Define FRAME_SCRAMBLER_HDR_EN to emit the SYNC/seed header; the default build is header-less.
module frame_scrambler (
  input  logic       clk1,
  input  logic       rst,
  input  logic [7:0] pattern_in,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic [7:0] frame_cnt
);

`ifdef FRAME_SCRAMBLER_HDR_EN
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
`else
  logic unused_pattern;
  assign unused_pattern = ^pattern_in;
`endif

  localparam logic [7:0] KEY_INIT = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEED    = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] key_q, key_d;
  logic [7:0] m_data_q, m_data_d;
  logic       m_valid_q, m_valid_d;
  logic       m_last_q, m_last_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       or_free;
  logic       load;
  logic [7:0] payload_key;

  function automatic logic [7:0] step(input logic [7:0] k);
    return {k[6:0], k[0] ^ k[1] ^ k[2] ^ k[7]};
  endfunction

  assign or_free = !m_valid_q || m_ready;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    frame_cnt_d = frame_cnt_q;
    load        = 1'b0;
    s_ready     = 1'b0;
    payload_key = key_q;

    case (state_q)
      ST_IDLE: begin
`ifdef FRAME_SCRAMBLER_HDR_EN
        // The pending input byte only triggers the header; it is consumed later in PAYLOAD.
        if (s_valid && or_free) begin
          load     = 1'b1;
          m_data_d = SYNC_BYTE;
          m_last_d = 1'b0;
          key_d    = (pattern_in == 8'h00) ? KEY_INIT : pattern_in;
          state_d  = ST_SEED;
        end
`else
        s_ready     = or_free;
        payload_key = KEY_INIT;
`endif
      end
      ST_SEED: begin
        if (or_free) begin
          load     = 1'b1;
          m_data_d = key_q;
          m_last_d = 1'b0;
          state_d  = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: s_ready = or_free;
      default:    state_d = ST_IDLE;
    endcase

    if (s_valid && s_ready) begin
      load     = 1'b1;
      m_data_d = s_data ^ payload_key;
      m_last_d = s_last;
      key_d    = step(payload_key);
      state_d  = s_last ? ST_IDLE : ST_PAYLOAD;
      if (s_last) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end

    m_valid_d = load || (m_valid_q && !m_ready);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      key_q       <= KEY_INIT;
      m_data_q    <= 8'h00;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      frame_cnt_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_frame_scrambler.sv
// tb/tb_frame_scrambler.sv - randomized bench for frame_scrambler against a frame-level model
`timescale 1ns/1ps
module tb_frame_scrambler;
  logic       clk1 = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pattern_in = 8'h00;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       m_ready = 1'b0;
  logic       s_ready, m_valid, m_last;
  logic [7:0] m_data, frame_cnt;

  frame_scrambler dut (
    .clk1(clk1), .rst(rst), .pattern_in(pattern_in),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .frame_cnt(frame_cnt)
  );

  always #5 clk1 = ~clk1;

`ifdef FRAME_SCRAMBLER_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif
  localparam int BUDGET = 20000;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] q_data[$], q_seed[$], e_data[$], obs_data[$], stall_data[$];
  bit         q_last[$], e_last[$], obs_last[$], stall_sready[$], stall_mvalid[$];
  int         obs_cyc[$];
  bit         timed_out;
  logic [7:0] exp_cnt;

  function automatic logic [7:0] step_key(input logic [7:0] k);
    int v;
    v = (int'(k) * 2) % 256 + ($countones(k & 8'h87) % 2);
    return v[7:0];
  endfunction

  task automatic clear_frames();
    q_data.delete(); q_last.delete(); q_seed.delete();
  endtask

  task automatic add_frame(input logic [7:0] seed, input int len, input int fill);
    q_seed.push_back(seed);
    for (int i = 0; i < len; i++) begin
      q_data.push_back(fill < 0 ? 8'($urandom) : 8'(fill));
      q_last.push_back(i == len - 1);
    end
  endtask

  // Expected output stream built frame by frame from the scrambling rules.
  task automatic build_expected();
    logic [7:0] k;
    int f;
    bit start;
    e_data.delete(); e_last.delete();
    f = 0; start = 1'b1; k = 8'h01;
    foreach (q_data[i]) begin
      if (start) begin
        k = 8'h01;
        if (HDR) begin
          if (q_seed[f] != 8'h00) k = q_seed[f];
          e_data.push_back(8'hA5); e_last.push_back(1'b0);
          e_data.push_back(k);     e_last.push_back(1'b0);
        end
        start = 1'b0;
      end
      e_data.push_back(q_data[i] ^ k); e_last.push_back(q_last[i]);
      k = step_key(k);
      if (q_last[i]) begin f++; start = 1'b1; end
    end
    exp_cnt = exp_cnt + 8'(q_seed.size());
  endtask

  task automatic do_reset();
    @(negedge clk1);
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk1);
    rst = 1'b0;
    exp_cnt = 8'h00;
  endtask

  task automatic drive_frames(input int valid_pct, input int ready_pct, input int stall_after, input int n_exp);
    int bi, f, cyc, stall_left;
    bit first, pend_acc, stalled_once;
    bi = 0; f = 0; cyc = 0; stall_left = 0;
    first = 1'b1; pend_acc = 1'b0; stalled_once = 1'b0;
    obs_data.delete(); obs_last.delete(); obs_cyc.delete();
    stall_data.delete(); stall_sready.delete(); stall_mvalid.delete();
    s_valid = 1'b0;
    while ((bi < q_data.size() || obs_data.size() < n_exp) && cyc < BUDGET) begin
      @(negedge clk1);
      cyc++;
      if (pend_acc) begin
        first = q_last[bi];
        if (q_last[bi]) f++;
        bi++;
        s_valid = 1'b0;
        pend_acc = 1'b0;
      end
      if (stall_after >= 0 && !stalled_once && obs_data.size() == stall_after) begin
        stall_left = 3; stalled_once = 1'b1;
      end
      if (stall_left > 0) m_ready = 1'b0;
      else m_ready = (int'($urandom_range(99)) < ready_pct);
      if (bi < q_data.size()) begin
        if (!s_valid) s_valid = (int'($urandom_range(99)) < valid_pct);
        s_data = q_data[bi];
        s_last = q_last[bi];
        pattern_in = first ? q_seed[f] : 8'($urandom);
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      #1;
      if (stall_left > 0) begin
        stall_data.push_back(m_data); stall_sready.push_back(s_ready); stall_mvalid.push_back(m_valid);
        stall_left--;
      end
      if (m_valid && m_ready) begin
        obs_data.push_back(m_data); obs_last.push_back(m_last); obs_cyc.push_back(cyc);
      end
      if (s_valid && s_ready) pend_acc = 1'b1;
    end
    timed_out = (cyc >= BUDGET);
    @(negedge clk1);
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    m_ready = 1'b1;
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    n_checks++; if (m_data !== 8'h00) begin n_errors++; $display("FAIL reset_m_data: got %h expected 00", m_data); end
    n_checks++; if (m_last !== 1'b0) begin n_errors++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
    n_checks++; if (frame_cnt !== 8'h00) begin n_errors++; $display("FAIL reset_frame_cnt: got %h expected 00", frame_cnt); end
    n_checks++; if (s_ready !== !HDR) begin n_errors++; $display("FAIL reset_s_ready: got %b expected %b", s_ready, !HDR); end
    m_ready = 1'b0;
  endtask

  task automatic test_basic();
    logic [47:0] packed_obs, lit;
    clear_frames(); add_frame(8'h01, 3, 0); build_expected();
    drive_frames(100, 100, -1, e_data.size());
    n_checks++; if (timed_out) begin n_errors++; $display("FAIL basic_timeout: got timeout expected completion"); end
    n_checks++; if (obs_data.size() != e_data.size()) begin n_errors++; $display("FAIL basic_len: got %0d expected %0d", obs_data.size(), e_data.size()); end
    packed_obs = '0;
    for (int i = 0; i < obs_data.size() && i < e_data.size(); i++) begin
      packed_obs = {packed_obs[39:0], obs_data[i]};
      n_checks++;
      if (obs_data[i] !== e_data[i] || obs_last[i] !== e_last[i])
        begin n_errors++; $display("FAIL basic_byte[%0d]: got %h/%b expected %h/%b", i, obs_data[i], obs_last[i], e_data[i], e_last[i]); end
    end
    lit = HDR ? 48'h00A501010306 : 48'h000000010306;
    n_checks++; if (packed_obs !== lit) begin n_errors++; $display("FAIL basic_stream: got %h expected %h", packed_obs, lit); end
    n_checks++; if (frame_cnt !== exp_cnt) begin n_errors++; $display("FAIL basic_frame_cnt: got %h expected %h", frame_cnt, exp_cnt); end
  endtask

  task automatic test_zero_seed();
    logic [47:0] packed_obs, lit;
    clear_frames(); add_frame(8'h00, 4, 0); build_expected();
    drive_frames(100, 100, -1, e_data.size());
    n_checks++; if (timed_out) begin n_errors++; $display("FAIL zero_seed_timeout: got timeout expected completion"); end
    packed_obs = '0;
    foreach (obs_data[i]) packed_obs = {packed_obs[39:0], obs_data[i]};
    lit = HDR ? 48'hA5010103060C : 48'h00000103060C;
    n_checks++; if (packed_obs !== lit) begin n_errors++; $display("FAIL zero_seed_stream: got %h expected %h", packed_obs, lit); end
    n_checks++; if (frame_cnt !== exp_cnt) begin n_errors++; $display("FAIL zero_seed_frame_cnt: got %h expected %h", frame_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure();
    int sa;
    sa = HDR ? 4 : 2;
    clear_frames(); add_frame(8'($urandom), 8, -1); build_expected();
    drive_frames(100, 100, sa, e_data.size());
    n_checks++; if (timed_out) begin n_errors++; $display("FAIL bp_timeout: got timeout expected completion"); end
    n_checks++; if (stall_data.size() != 3) begin n_errors++; $display("FAIL bp_stall_len: got %0d expected 3", stall_data.size()); end
    foreach (stall_data[i]) begin
      n_checks++;
      if (stall_data[i] !== e_data[sa] || stall_mvalid[i] !== 1'b1 || stall_sready[i] !== 1'b0)
        begin n_errors++; $display("FAIL bp_hold[%0d]: got data %h valid %b s_ready %b expected %h 1 0", i, stall_data[i], stall_mvalid[i], stall_sready[i], e_data[sa]); end
    end
    n_checks++; if (obs_data.size() != e_data.size()) begin n_errors++; $display("FAIL bp_len: got %0d expected %0d", obs_data.size(), e_data.size()); end
    for (int i = 0; i < obs_data.size() && i < e_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== e_data[i] || obs_last[i] !== e_last[i])
        begin n_errors++; $display("FAIL bp_byte[%0d]: got %h/%b expected %h/%b", i, obs_data[i], obs_last[i], e_data[i], e_last[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] packed_obs, lit;
    int gaps;
    clear_frames(); add_frame(8'h03, 1, 255); add_frame(8'h80, 1, 255); build_expected();
    drive_frames(100, 100, -1, e_data.size());
    n_checks++; if (timed_out) begin n_errors++; $display("FAIL b2b_timeout: got timeout expected completion"); end
    packed_obs = '0; gaps = 0;
    foreach (obs_data[i]) begin
      packed_obs = {packed_obs[39:0], obs_data[i]};
      if (i > 0 && obs_cyc[i] - obs_cyc[i-1] != 1) gaps++;
    end
    lit = HDR ? 48'hA503FCA5807F : 48'h00000000FEFE;
    n_checks++; if (packed_obs !== lit) begin n_errors++; $display("FAIL b2b_stream: got %h expected %h", packed_obs, lit); end
    n_checks++; if (gaps != 0) begin n_errors++; $display("FAIL b2b_bubbles: got %0d expected 0", gaps); end
    n_checks++; if (obs_last.size() != e_last.size() || obs_last != e_last) begin n_errors++; $display("FAIL b2b_last: got %p expected %p", obs_last, e_last); end
  endtask

  task automatic test_random();
    clear_frames();
    for (int f = 0; f < 30; f++)
      add_frame(($urandom_range(3) == 0) ? 8'h00 : 8'($urandom), int'($urandom_range(1, 8)), -1);
    build_expected();
    drive_frames(70, 60, -1, e_data.size());
    n_checks++; if (timed_out) begin n_errors++; $display("FAIL rand_timeout: got timeout expected completion"); end
    n_checks++; if (obs_data.size() != e_data.size()) begin n_errors++; $display("FAIL rand_len: got %0d expected %0d", obs_data.size(), e_data.size()); end
    for (int i = 0; i < obs_data.size() && i < e_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== e_data[i] || obs_last[i] !== e_last[i])
        begin n_errors++; $display("FAIL rand_byte[%0d]: got %h/%b expected %h/%b", i, obs_data[i], obs_last[i], e_data[i], e_last[i]); end
    end
    n_checks++; if (frame_cnt !== exp_cnt) begin n_errors++; $display("FAIL rand_frame_cnt: got %h expected %h", frame_cnt, exp_cnt); end
  endtask

  task automatic test_reset_midframe();
    int acc, cyc;
    do_reset();
    acc = 0; cyc = 0;
    pattern_in = 8'h5A;
    while (acc < 2 && cyc < 100) begin
      @(negedge clk1);
      cyc++;
      m_ready = 1'b1; s_valid = 1'b1; s_data = 8'($urandom); s_last = 1'b0;
      #1;
      if (s_valid && s_ready) acc++;
    end
    n_checks++; if (acc < 2) begin n_errors++; $display("FAIL rst_mid_timeout: got %0d accepts expected 2", acc); end
    @(negedge clk1);
    rst = 1'b1; s_valid = 1'b0;
    @(negedge clk1);
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_m_valid: got %b expected 0", m_valid); end
    n_checks++; if (s_ready !== !HDR) begin n_errors++; $display("FAIL rst_mid_s_ready: got %b expected %b", s_ready, !HDR); end
    n_checks++; if (frame_cnt !== 8'h00) begin n_errors++; $display("FAIL rst_mid_frame_cnt: got %h expected 00", frame_cnt); end
    rst = 1'b0; exp_cnt = 8'h00;
    clear_frames(); add_frame(8'h3C, 3, -1); build_expected();
    drive_frames(100, 100, -1, e_data.size());
    n_checks++;
    if (timed_out || obs_data.size() != e_data.size() || obs_data != e_data || obs_last != e_last)
      begin n_errors++; $display("FAIL rst_mid_restart: got %p expected %p", obs_data, e_data); end
    n_checks++;
    if (obs_data.size() == 0 || obs_data[0] !== (HDR ? 8'hA5 : (q_data[0] ^ 8'h01)))
      begin n_errors++; $display("FAIL rst_mid_first: got %p expected first %h", obs_data, HDR ? 8'hA5 : (q_data[0] ^ 8'h01)); end
    n_checks++; if (frame_cnt !== 8'h01) begin n_errors++; $display("FAIL rst_mid_cnt_after: got %h expected 01", frame_cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    clear_frames();
    for (int f = 0; f < 255; f++) add_frame(8'($urandom), 1, -1);
    build_expected();
    drive_frames(100, 100, -1, e_data.size());
    n_checks++;
    if (timed_out || obs_data != e_data || obs_last != e_last)
      begin n_errors++; $display("FAIL wrap_stream: got %0d bytes expected %0d matching bytes", obs_data.size(), e_data.size()); end
    n_checks++; if (frame_cnt !== 8'hFF) begin n_errors++; $display("FAIL wrap_cnt_ff: got %h expected ff", frame_cnt); end
    clear_frames(); add_frame(8'($urandom), 1, -1); build_expected();
    drive_frames(100, 100, -1, e_data.size());
    n_checks++; if (frame_cnt !== exp_cnt) begin n_errors++; $display("FAIL wrap_cnt_00: got %h expected %h", frame_cnt, exp_cnt); end
  endtask

  initial begin
    exp_cnt = 8'h00;
    test_reset();
    test_basic();
    test_zero_seed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/frame_scrambler.md
# frame_scrambler

Byte-stream scrambler that sits directly downstream of the 8-bit LFSR pattern generator and consumes its free-running `out_pattern1` word as a per-frame seed. Each input frame is emitted as a sync byte, a clear-text seed byte, then the payload XORed with a local keystream. The local keystream uses the same polynomial as the generator and advances once per accepted payload byte. The output feeds the serializer/link stage over a valid/ready interface.

## Interface
- `SYNC_BYTE`, 8'hA5, header marker emitted first in every frame (header builds only)
- `clk1`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `pattern_in`  in  8  free-running LFSR pattern from the generator
- `s_data`  in  8  input payload byte
- `s_valid`  in  1  input byte valid
- `s_last`  in  1  input byte is last of frame
- `s_ready`  out  1  input byte accepted when `s_valid && s_ready`
- `m_data`  out  8  output byte (registered)
- `m_valid`  out  1  output byte valid (registered)
- `m_last`  out  1  output byte is last of frame (registered)
- `m_ready`  in  1  downstream accepts when `m_valid && m_ready`
- `frame_cnt`  out  8  completed input frames, wraps 0xFF→0x00

## Operation
- Single output register (OR). It is "free" when `!m_valid || m_ready`. A load is permitted only when free.
- Step function: `step(k) = {k[6:0], k[0]^k[1]^k[2]^k[7]}`. This is identical to the generator.
- States are IDLE, SEED, PAYLOAD.
- **IDLE**
  - `s_ready`=0.
  - If `s_valid` and OR free: load OR = {`SYNC_BYTE`, last=0}, and set `key` to the capture seed. The capture seed is `pattern_in`, or 8'h01 if `pattern_in`==0.
  - Then go to SEED. The input byte is not consumed.
- **SEED**
  - `s_ready`=0.
  - When OR is free: load OR = {`key`, last=0}, then go to PAYLOAD.
- **PAYLOAD**
  - `s_ready` = OR free.
  - On accept: load OR = {`s_data ^ key`, `s_last`} and set `key <= step(key)`.
  - If `s_last`: increment `frame_cnt` and go to IDLE. `key` is not reused across frames.
- If OR is consumed and nothing is loaded in the same cycle, `m_valid` is cleared.
- A simultaneous consume and load in the same cycle is legal. This gives full throughput: one byte/cycle in PAYLOAD with `m_ready`=1.
- Reset mid-frame:
  - Frame is aborted and OR is discarded.
  - No partial-frame completion; `frame_cnt` is not incremented.
  - Upstream must restart the frame.

## Timing
- Reset values:
  - State IDLE, `m_valid`=0, `m_data`=8'h00, `m_last`=0.
  - `s_ready`=0, `frame_cnt`=0, `key`=8'h01.
- `s_ready` is combinational from state and `m_valid`/`m_ready`.
- Header overhead is 2 cycles per frame. The first payload byte is accepted no earlier than 2 cycles after the IDLE-exit edge.
- Payload latency is 1 cycle from accept to `m_valid`.
- Back-to-back frames: the cycle after last-byte accept is IDLE, which can load SYNC when OR is free. The minimum frame gap on output is 0 bubbles.
- With `m_ready`=0, `m_data`/`m_last` hold stable and `key` does not advance.
- `pattern_in` is sampled only at the IDLE→SEED edge.

## Configuration
- `FRAME_SCRAMBLER_HDR_EN`
- **Defined**
  - Behaviour is as above.
  - SYNC and SEED bytes are emitted and the seed is taken from `pattern_in`.
- **Undefined**
  - No header is emitted and the SEED state is removed.
  - IDLE loads nothing. If OR is free, IDLE asserts `s_ready` and treats an accept exactly as a PAYLOAD accept, using `key`=8'h01.
  - `key` is reloaded to 8'h01 at each frame's first accepted byte.
  - `pattern_in` and `SYNC_BYTE` are unused.

## Test plan
- Header build, `m_ready`=1, `pattern_in`=0x01, frame 00,00,00 (last on third) → m stream A5,01,01,03,06; `m_last` only on 06; `frame_cnt`=1.
- `pattern_in`=0x00 at capture → seed byte 0x01, payload keystream 01,03,06,0C.
- Backpressure: drop `m_ready` for 3 cycles mid-payload → `m_data` held, `s_ready`=0, no key step; after release the stream is identical to the no-stall case.
- Two back-to-back 1-byte frames, `pattern_in`=0x03 then 0x80, payload 0xFF each → A5,03,FC,A5,80,7F with no idle cycle.
- Assert `rst` after the 2nd payload byte → next cycle `m_valid`=0, `s_ready`=0, `frame_cnt` unchanged at 0; the next frame starts with A5.
- Header-less build, frame 00,00,00 → 01,03,06; after 256 frames `frame_cnt` wraps to 0x00.
